// File: rtl/pic_irr.sv
// Interrupt request register for an 8259-style PIC: synchronizes the IR lines, qualifies them
// as level- or edge-triggered, applies the mask and presents the pending-request vector.
module pic_irr #(
   parameter int unsigned N_IR        = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            Level_Edge_flag,
   input  logic [N_IR-1:0] Mask,
   input  logic [N_IR-1:0] I_WIRES,
   input  logic [N_IR-1:0] Clear,
   output logic [N_IR-1:0] IRR
);

   logic [N_IR-1:0] sync_q [SYNC_STAGES];
   logic [N_IR-1:0] ir_s;
   logic [N_IR-1:0] ir_d_q;
   logic [N_IR-1:0] rise;
   logic [N_IR-1:0] latch_q, latch_d;
   logic [N_IR-1:0] irr_q, irr_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q[0] <= I_WIRES;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign ir_s = sync_q[SYNC_STAGES-1];

   always_comb begin
      rise    = ir_s & ~ir_d_q;
      latch_d = '0;
      irr_d   = '0;
      if (Level_Edge_flag) begin
         // Latches are held clear in level mode so a switch to edge mode needs a fresh rise.
         irr_d = ir_s & ~Mask;
      end else begin
         // A rise coincident with Clear wins; masking never touches the latch.
         latch_d = (latch_q | rise) & ~(Clear & ~rise);
         irr_d   = latch_d & ir_s & ~Mask;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ir_d_q  <= '0;
         latch_q <= '0;
         irr_q   <= '0;
      end else begin
         ir_d_q  <= ir_s;
         latch_q <= latch_d;
         irr_q   <= irr_d;
      end
   end

   assign IRR = irr_q;

endmodule

// File: tb/tb_pic_irr.sv
// Self-checking bench for pic_irr: directed scenarios with fixed expectations, then a
// randomized run against a per-bit behavioural model driven by a wire-history queue.
module tb_pic_irr;

   localparam int N  = 8;
   localparam int SS = 2;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         flag = 1'b0;
   logic [N-1:0] mask = '0;
   logic [N-1:0] wires = '0;
   logic [N-1:0] clr = '0;
   logic [N-1:0] IRR;

   int checks = 0;
   int errors = 0;

   // Model state: history of applied wire values (newest first), per-bit edge arming.
   logic [N-1:0] hist[$];
   bit           armed[N];
   logic [N-1:0] exp_irr;

   pic_irr #(.N_IR(N), .SYNC_STAGES(SS)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .Level_Edge_flag (flag),
      .Mask            (mask),
      .I_WIRES         (wires),
      .Clear           (clr),
      .IRR             (IRR)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      hist.delete();
      for (int i = 0; i <= SS; i++) hist.push_back('0);
      for (int b = 0; b < N; b++) armed[b] = 0;
      exp_irr = '0;
   endtask

   // Advance one clock; the model sees the inputs that were present at the edge.
   task automatic step();
      logic [N-1:0] w, c, m, s, d;
      bit f;
      w = wires; c = clr; m = mask; f = flag;
      @(posedge clk);
      s = hist[SS-1];  // synchronized wire seen at this edge
      d = hist[SS];    // its value one clock earlier
      for (int b = 0; b < N; b++) begin
         if (f) armed[b] = 0;
         else if (s[b] && !d[b]) armed[b] = 1;
         else if (c[b]) armed[b] = 0;
         exp_irr[b] = s[b] && !m[b] && (f || armed[b]);
      end
      hist.push_front(w);
      void'(hist.pop_back());
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flag = 1'b0; mask = 8'h00; wires = 8'h55; clr = 8'h00;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (IRR !== 8'h00) begin
         errors++; $display("FAIL reset_state got %h want 00", IRR);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_edge_basic();
      logic [N-1:0] want[5] = '{8'h00, 8'h00, 8'h55, 8'h55, 8'h55};
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if (IRR !== want[i]) begin
            errors++; $display("FAIL edge_basic clk%0d got %h want %h", i + 1, IRR, want[i]);
         end
      end
   endtask

   task automatic test_level_mode();
      logic [N-1:0] want[3] = '{8'h55, 8'h55, 8'hAA};
      flag = 1'b1; wires = 8'hAA;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (IRR !== want[i]) begin
            errors++; $display("FAIL level_mode clk%0d got %h want %h", i + 1, IRR, want[i]);
         end
      end
      clr = 8'hFF;
      step();
      clr = 8'h00;
      step();
      checks++;
      if (IRR !== 8'hAA) begin
         errors++; $display("FAIL level_clear_ignored got %h want aa", IRR);
      end
   endtask

   task automatic test_mode_switch();
      logic [N-1:0] want[3] = '{8'h00, 8'h00, 8'h44};
      flag = 1'b0; wires = 8'hCC;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (IRR !== want[i]) begin
            errors++; $display("FAIL mode_switch clk%0d got %h want %h", i + 1, IRR, want[i]);
         end
      end
   endtask

   task automatic test_mask_clear();
      mask = 8'h04; step(); checks++;
      if (IRR !== 8'h40) begin errors++; $display("FAIL mask_on got %h want 40", IRR); end
      mask = 8'h00; step(); checks++;
      if (IRR !== 8'h44) begin errors++; $display("FAIL mask_off got %h want 44", IRR); end
      clr = 8'h40; step(); clr = 8'h00; checks++;
      if (IRR !== 8'h04) begin errors++; $display("FAIL clear_ir6 got %h want 04", IRR); end
      wires = 8'h8C; repeat (3) step(); checks++;
      if (IRR !== 8'h04) begin errors++; $display("FAIL drop_ir6 got %h want 04", IRR); end
      wires = 8'hCC; repeat (3) step(); checks++;
      if (IRR !== 8'h44) begin errors++; $display("FAIL raise_ir6 got %h want 44", IRR); end
   endtask

   task automatic test_edge_fall();
      clr = 8'hFF; step(); clr = 8'h00; checks++;
      if (IRR !== 8'h00) begin errors++; $display("FAIL clear_all got %h want 00", IRR); end
      wires = 8'h01; repeat (3) step(); checks++;
      if (IRR !== 8'h01) begin errors++; $display("FAIL ir0_rise got %h want 01", IRR); end
      wires = 8'h00; repeat (3) step(); checks++;
      if (IRR !== 8'h00) begin errors++; $display("FAIL ir0_fall got %h want 00", IRR); end
      wires = 8'h01; repeat (3) step(); checks++;
      if (IRR !== 8'h01) begin errors++; $display("FAIL ir0_reraise got %h want 01", IRR); end
   endtask

   task automatic test_async_reset();
      logic [N-1:0] want[3] = '{8'h00, 8'h00, 8'hFF};
      flag = 1'b1; wires = 8'hFF;
      repeat (3) step();
      checks++;
      if (IRR !== 8'hFF) begin errors++; $display("FAIL pre_reset got %h want ff", IRR); end
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (IRR !== 8'h00) begin errors++; $display("FAIL async_reset got %h want 00", IRR); end
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (IRR !== want[i]) begin
            errors++; $display("FAIL post_reset clk%0d got %h want %h", i + 1, IRR, want[i]);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) wires = N'($urandom);
         if ($urandom_range(0, 7) == 0) mask = N'($urandom) & N'($urandom);
         clr = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
         if ($urandom_range(0, 49) == 0) flag = ~flag;
         step();
         checks++;
         if (IRR !== exp_irr) begin
            errors++;
            $display("FAIL random cyc%0d got %h want %h", i, IRR, exp_irr);
         end
      end
   endtask

   initial begin
      test_reset();
      test_edge_basic();
      test_level_mode();
      test_mode_switch();
      test_mask_clear();
      test_edge_fall();
      test_async_reset();
      flag = 1'b0; mask = '0; clr = '0;
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
